// File: rtl/cpu_stack_ctl.sv
// Hardware stack controller: TOS/NOS are held in registers, deeper entries spill to a
// single-port RAM. Each request pops 0-3 entries and then optionally pushes one.
module cpu_stack_ctl #(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              req_valid_4a,
  input  logic              kill_4a,
  input  logic [1:0]        pop_cnt_4a,
  input  logic              push_4a,
  input  logic [34:0]       push_data_4a,
  output logic              ready,
  output logic [34:0]       tos,
  output logic [34:0]       nos,
  output logic              tos_valid,
  output logic              nos_valid,
  output logic [RAM_AW:0]   count,
  output logic              err_under,
  output logic              err_over,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [34:0]       ram_wdata,
  input  logic [34:0]       ram_rdata
);

  localparam int CW = RAM_AW + 1;
  localparam logic [CW:0] CAP = (CW+1)'((1 << RAM_AW) + 2);

  typedef enum logic [1:0] {IDLE, POP, FILL, PUSH} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [34:0]     tos_q, tos_d;
  logic [34:0]     nos_q, nos_d;
  logic [34:0]     data_q, data_d;
  logic [1:0]      pops_q, pops_d;
  logic            push_q, push_d;
  logic            err_under_q, err_under_d;
  logic            err_over_q, err_over_d;

  logic [1:0]      pops_dec;
  logic [CW:0]     depth_after;

  // Where the sequence goes once the current pop has fully retired.
  function automatic state_t after_pop(input logic [1:0] rem, input logic psh);
    if (rem != 2'd0)  return POP;
    else if (psh)     return PUSH;
    else              return IDLE;
  endfunction

  assign pops_dec    = pops_q - 2'd1;
  assign depth_after = {1'b0, count_q} - (CW+1)'(pop_cnt_4a) + (CW+1)'(push_4a);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      count_q     <= '0;
      tos_q       <= '0;
      nos_q       <= '0;
      data_q      <= '0;
      pops_q      <= '0;
      push_q      <= 1'b0;
      err_under_q <= 1'b0;
      err_over_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      tos_q       <= tos_d;
      nos_q       <= nos_d;
      data_q      <= data_d;
      pops_q      <= pops_d;
      push_q      <= push_d;
      err_under_q <= err_under_d;
      err_over_q  <= err_over_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    tos_d       = tos_q;
    nos_d       = nos_q;
    data_d      = data_q;
    pops_d      = pops_q;
    push_d      = push_q;
    err_under_d = err_under_q;
    err_over_d  = err_over_q;
    ram_re      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (req_valid_4a && !kill_4a) begin
          // Error checks run first so an illegal request never disturbs the stack.
          if (CW'(pop_cnt_4a) > count_q) begin
            err_under_d = 1'b1;
          end else if (depth_after > CAP) begin
            err_over_d = 1'b1;
          end else begin
            pops_d  = pop_cnt_4a;
            push_d  = push_4a;
            data_d  = push_data_4a;
            state_d = after_pop(pop_cnt_4a, push_4a);
          end
        end
      end
      POP: begin
        tos_d   = nos_q;
        count_d = count_q - CW'(1);
        if (count_q >= CW'(3)) begin
          ram_re   = 1'b1;
          ram_addr = RAM_AW'(count_q - CW'(3));
          state_d  = FILL;
        end else begin
          pops_d  = pops_dec;
          state_d = after_pop(pops_dec, push_q);
        end
      end
      FILL: begin
        nos_d   = ram_rdata;
        pops_d  = pops_dec;
        state_d = after_pop(pops_dec, push_q);
      end
      PUSH: begin
        if (count_q >= CW'(2)) begin
          ram_we    = 1'b1;
          ram_addr  = RAM_AW'(count_q - CW'(2));
          ram_wdata = nos_q;
        end
        nos_d   = tos_q;
        tos_d   = data_q;
        count_d = count_q + CW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready     = (state_q == IDLE);
  assign tos       = tos_q;
  assign nos       = nos_q;
  assign count     = count_q;
  assign tos_valid = (count_q >= CW'(1));
  assign nos_valid = (count_q >= CW'(2));
  assign err_under = err_under_q;
  assign err_over  = err_over_q;

endmodule

// File: tb/tb_cpu_stack_ctl.sv
// Directed bench for cpu_stack_ctl with a small behavioural RAM (RAM_AW=3, capacity 10).
module tb_cpu_stack_ctl;

  localparam int AW  = 3;
  localparam int CAP = (1 << AW) + 2;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          req_valid_4a = 1'b0;
  logic          kill_4a = 1'b0;
  logic [1:0]    pop_cnt_4a = 2'd0;
  logic          push_4a = 1'b0;
  logic [34:0]   push_data_4a = '0;
  logic          ready;
  logic [34:0]   tos, nos;
  logic          tos_valid, nos_valid;
  logic [AW:0]   count;
  logic          err_under, err_over;
  logic [AW-1:0] ram_addr;
  logic          ram_re, ram_we;
  logic [34:0]   ram_wdata;
  logic [34:0]   ram_rdata = '0;

  logic [34:0]   mem [0:(1<<AW)-1];
  int            checks = 0;
  int            passes = 0;
  int            we_cnt = 0, re_cnt = 0, overlap = 0;
  logic [AW-1:0] last_we_addr = '0, last_re_addr = '0;
  logic [34:0]   last_wdata = '0;

  cpu_stack_ctl #(.RAM_AW(AW)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid_4a(req_valid_4a), .kill_4a(kill_4a), .pop_cnt_4a(pop_cnt_4a),
    .push_4a(push_4a), .push_data_4a(push_data_4a),
    .ready(ready), .tos(tos), .nos(nos), .tos_valid(tos_valid), .nos_valid(nos_valid),
    .count(count), .err_under(err_under), .err_over(err_over),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM: read data appears the cycle after ram_re.
  always @(posedge clk) begin
    if (ram_we && ram_re) overlap++;
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
      we_cnt++;
      last_we_addr = ram_addr;
      last_wdata   = ram_wdata;
    end
    if (ram_re) begin
      ram_rdata <= mem[ram_addr];
      re_cnt++;
      last_re_addr = ram_addr;
    end
  end

  task automatic send(input logic [1:0] pc, input logic ph, input logic [34:0] d,
                      input logic kl, output int busy);
    @(negedge clk);
    req_valid_4a = 1'b1; kill_4a = kl; pop_cnt_4a = pc; push_4a = ph; push_data_4a = d;
    @(negedge clk);
    req_valid_4a = 1'b0; kill_4a = 1'b0; pop_cnt_4a = 2'd0; push_4a = 1'b0;
    busy = 0;
    while (!ready && busy < 20) begin
      busy++;
      @(negedge clk);
    end
    checks++;
    if (busy >= 20) $display("FAIL handshake_timeout: ready still %0b after %0d cycles, required 1", ready, busy);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if ({ready, tos_valid, nos_valid, err_under, err_over} !== 5'b10000)
      $display("FAIL reset_flags: got %b required 10000", {ready, tos_valid, nos_valid, err_under, err_over});
    else passes++;
    checks++;
    if ({count, tos, nos} !== '0) $display("FAIL reset_regs: count=%0d tos=%0h nos=%0h required all 0", count, tos, nos);
    else passes++;
    checks++;
    if ({ram_re, ram_we} !== 2'b00) $display("FAIL reset_ram_ctl: re/we=%b required 00", {ram_re, ram_we});
    else passes++;
  endtask

  task automatic test_push3();
    int b;
    for (int i = 1; i <= 3; i++) begin
      send(2'd0, 1'b1, 35'(i), 1'b0, b);
      checks++;
      if (b !== 1) $display("FAIL push_latency_%0d: busy=%0d required 1", i, b);
      else passes++;
    end
    checks++;
    if ({tos, nos, count} !== {35'd3, 35'd2, 4'd3})
      $display("FAIL push3_state: tos=%0d nos=%0d count=%0d required 3 2 3", tos, nos, count);
    else passes++;
    checks++;
    if ({we_cnt, last_we_addr, last_wdata} !== {32'd1, 3'd0, 35'd1})
      $display("FAIL push3_ram_write: writes=%0d addr=%0d data=%0d required 1 0 1", we_cnt, last_we_addr, last_wdata);
    else passes++;
  endtask

  task automatic test_pop_fill();
    int b;
    send(2'd2, 1'b0, '0, 1'b0, b);
    checks++;
    if (b !== 3) $display("FAIL pop2_latency: busy=%0d required 3", b);
    else passes++;
    checks++;
    if ({re_cnt, last_re_addr} !== {32'd1, 3'd0})
      $display("FAIL pop2_ram_read: reads=%0d addr=%0d required 1 0", re_cnt, last_re_addr);
    else passes++;
    checks++;
    if ({tos, nos_valid, tos_valid, count} !== {35'd1, 1'b0, 1'b1, 4'd1})
      $display("FAIL pop2_state: tos=%0d nos_valid=%0b tos_valid=%0b count=%0d required 1 0 1 1",
               tos, nos_valid, tos_valid, count);
    else passes++;
  endtask

  task automatic test_underflow();
    int b;
    send(2'd2, 1'b0, '0, 1'b0, b);
    checks++;
    if ({err_under, err_over, b[0], ready, count} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd1})
      $display("FAIL underflow: err_under=%0b err_over=%0b busy=%0d ready=%0b count=%0d required 1 0 0 1 1",
               err_under, err_over, b, ready, count);
    else passes++;
  endtask

  task automatic test_kill();
    int b;
    int w0;
    w0 = we_cnt;
    send(2'd0, 1'b1, 35'h77, 1'b1, b);
    checks++;
    if ({count, tos, b[4:0]} !== {4'd1, 35'd1, 5'd0} || we_cnt != w0)
      $display("FAIL kill_request: count=%0d tos=%0h busy=%0d required 1 1 0", count, tos, b);
    else passes++;
  endtask

  task automatic test_overflow();
    int b;
    int w0;
    for (int i = 0; i < CAP - 1; i++) send(2'd0, 1'b1, 35'(100 + i), 1'b0, b);
    checks++;
    if ({count, tos, nos, err_over} !== {4'(CAP), 35'd108, 35'd107, 1'b0})
      $display("FAIL fill_to_cap: count=%0d tos=%0d nos=%0d err_over=%0b required %0d 108 107 0",
               count, tos, nos, err_over, CAP);
    else passes++;
    w0 = we_cnt;
    send(2'd0, 1'b1, 35'h3f, 1'b0, b);
    checks++;
    if ({err_over, count, tos} !== {1'b1, 4'(CAP), 35'd108} || we_cnt != w0 || b != 0)
      $display("FAIL overflow: err_over=%0b count=%0d tos=%0d writes=%0d busy=%0d required 1 %0d 108 %0d 0",
               err_over, count, tos, we_cnt, b, CAP, w0);
    else passes++;
    send(2'd1, 1'b1, 35'h5, 1'b0, b);
    checks++;
    if ({count, tos, nos} !== {4'(CAP), 35'h5, 35'd107} || b != 3)
      $display("FAIL pop_push_at_cap: count=%0d tos=%0h nos=%0d busy=%0d required %0d 5 107 3", count, tos, nos, b, CAP);
    else passes++;
    checks++;
    if ({err_under, err_over} !== 2'b11) $display("FAIL sticky_errors: got %b required 11", {err_under, err_over});
    else passes++;
  endtask

  task automatic test_kill_in_fill();
    @(negedge clk);
    req_valid_4a = 1'b1; pop_cnt_4a = 2'd1;
    @(negedge clk);
    req_valid_4a = 1'b0; pop_cnt_4a = 2'd0;
    @(negedge clk);
    // Now in FILL: a killed (and a would-be new) request must both be ignored.
    req_valid_4a = 1'b1; kill_4a = 1'b1; push_4a = 1'b1; push_data_4a = 35'h99;
    @(negedge clk);
    req_valid_4a = 1'b0; kill_4a = 1'b0; push_4a = 1'b0;
    checks++;
    if ({ready, tos, nos, count} !== {1'b1, 35'd107, 35'd106, 4'd9} || last_re_addr != 3'd7)
      $display("FAIL kill_in_fill: ready=%0b tos=%0d nos=%0d count=%0d raddr=%0d required 1 107 106 9 7",
               ready, tos, nos, count, last_re_addr);
    else passes++;
  endtask

  task automatic test_reset_mid_fill();
    int b;
    int w0;
    @(negedge clk);
    req_valid_4a = 1'b1; pop_cnt_4a = 2'd1;
    @(negedge clk);
    req_valid_4a = 1'b0; pop_cnt_4a = 2'd0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    checks++;
    if ({ready, tos_valid, nos_valid, err_under, err_over, ram_re, ram_we} !== 7'b1000000 ||
        {count, tos, nos} !== '0)
      $display("FAIL reset_mid_fill: ready=%0b count=%0d tos=%0h nos=%0h errs=%b re/we=%b required 1 0 0 0 00 00",
               ready, count, tos, nos, {err_under, err_over}, {ram_re, ram_we});
    else passes++;
    @(negedge clk);
    rst_b = 1'b1;
    w0 = we_cnt;
    send(2'd0, 1'b1, 35'h7, 1'b0, b);
    checks++;
    if ({tos, count, tos_valid, nos_valid} !== {35'h7, 4'd1, 1'b1, 1'b0} || b != 1 || we_cnt != w0)
      $display("FAIL post_reset_push: tos=%0h count=%0d valids=%b busy=%0d required 7 1 10 1",
               tos, count, {tos_valid, nos_valid}, b);
    else passes++;
  endtask

  task automatic test_ram_protocol();
    checks++;
    if (overlap !== 0) $display("FAIL ram_re_we_overlap: cycles=%0d required 0", overlap);
    else passes++;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_b = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1) $display("FAIL ready_after_reset: got %0b required 1", ready);
    else passes++;
    test_push3();
    test_pop_fill();
    test_underflow();
    test_kill();
    test_overflow();
    test_kill_in_fill();
    test_reset_mid_fill();
    test_ram_protocol();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_stack_ctl.md
CPU_STACK_CTL -- requirements
Module: cpu_stack_ctl

Interface
REQ-001 SHALL have parameter RAM_AW, default 10, meaning stack RAM address width; capacity CAP = 2^RAM_AW + 2 entries.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_4a  input  1  stack request present.
REQ-005 SHALL have port kill_4a  input  1  squash the same-cycle request.
REQ-006 SHALL have port pop_cnt_4a  input  2  entries to pop (0-3).
REQ-007 SHALL have port push_4a  input  1  push one entry after the pops.
REQ-008 SHALL have port push_data_4a  input  35  tagged value to push.
REQ-009 SHALL have port ready  output  1  controller accepts a request this cycle.
REQ-010 SHALL have ports tos, nos  output  35 each  top and next-on-stack registers.
REQ-011 SHALL have ports tos_valid, nos_valid  output  1 each  count>=1 and count>=2.
REQ-012 SHALL have port count  output  RAM_AW+1  current stack depth.
REQ-013 SHALL have ports err_under, err_over  output  1 each  sticky error flags.
REQ-014 SHALL have ports ram_addr  output  RAM_AW; ram_re, ram_we  output  1 each; ram_wdata  output  35; ram_rdata  input  35  single-port RAM, read data valid the cycle after ram_re.

Function
REQ-015 Entries below NOS SHALL live in RAM; the deepest entry is at address 0 and the RAM top is at count-3.
REQ-016 FSM states SHALL be IDLE, POP, FILL, PUSH; ready=1 only in IDLE.
REQ-017 A request SHALL be accepted when IDLE && req_valid_4a && !kill_4a; killed or unaccepted requests have no effect.
REQ-018 On accept, underflow (pop_cnt > count) SHALL set err_under, drop the request, and stay IDLE.
REQ-019 On accept, overflow (count - pop_cnt + push > CAP) SHALL set err_over, drop the request, and stay IDLE.
REQ-020 A legal request SHALL latch pop_cnt, push and push_data, then go to POP if pop_cnt>0, else PUSH if push, else remain IDLE.
REQ-021 POP (1 cycle) SHALL do tos<=nos and count<=count-1.
REQ-022 In POP with pre-decrement count>=3, the block SHALL drive ram_re=1 with ram_addr=count-3 and go to FILL.
REQ-023 Otherwise POP SHALL decrement the remaining pops and go to POP if any remain, else PUSH if push is latched, else IDLE.
REQ-024 FILL (1 cycle) SHALL do nos<=ram_rdata, decrement the remaining pops, and take the same next-state choice as REQ-023.
REQ-025 PUSH (1 cycle) SHALL do nos<=tos, tos<=latched data and count<=count+1, then go to IDLE.
REQ-026 In PUSH with count>=2, the block SHALL drive ram_we=1, ram_addr=count-2 and ram_wdata=nos.
REQ-027 ram_re and ram_we SHALL never assert together and SHALL be 0 in IDLE.
REQ-028 Invalid tos/nos (valid flag 0) SHALL hold their previous value, never X.
REQ-029 Latency: total non-ready cycles = pops + RAM refills + push; a push-only request costs 1 cycle.
REQ-030 kill_4a outside IDLE SHALL be ignored; an in-flight sequence always completes.
REQ-031 err_under and err_over SHALL stay set until reset; later requests are still serviced.
REQ-032 count arithmetic SHALL use RAM_AW+1 bits; the error checks guarantee count never wraps.

Reset
REQ-033 Asserting rst_b low SHALL immediately force IDLE, count=0, tos=nos=0, all valid and error flags 0, and ram_re=ram_we=0, aborting any sequence.
REQ-034 After rst_b deasserts, ready SHALL be 1 on the first clock.

Verification
REQ-035 Three push-only requests (data 1, 2, 3) -> tos=3, nos=2, count=3, one ram_we at addr 0 with wdata 1, ready low 1 cycle each.
REQ-036 From the REQ-035 state, pop_cnt=2 with no push -> POP, FILL (ram_re addr 0), POP; end with tos=1, nos_valid=0, count=1, ready low 3 cycles.
REQ-037 From count=1, pop_cnt=2 -> err_under=1, count unchanged at 1, ready stays 1.
REQ-038 Fill to CAP, then a push-only request -> err_over=1, count=CAP, no ram_we; then pop_cnt=1 with push (data 0x5) -> count=CAP, tos=0x5.
REQ-039 Request with kill_4a=1 -> no state change; kill_4a pulsed during FILL -> sequence completes normally.
REQ-040 rst_b asserted mid-FILL -> outputs immediately at reset values; first request after release behaves as from an empty stack.
